// File: rtl/spike_dispatcher.sv
// spike_dispatcher: latches a tile's fire vector and streams each fired neuron as a
// source address over valid/ready, then pulses clear. SPIKE_DISPATCH_COUNT_EN adds spike_count.

module spike_dispatcher #(
   parameter int NUM_NEURONS = 8,
   parameter int ADDR_W      = 12
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [ADDR_W-1:0]      base_address,
   input  logic [NUM_NEURONS-1:0] fire_vector,
   input  logic                   timestep_done,
   output logic [ADDR_W-1:0]      source_address,
   output logic                   spike_valid,
   input  logic                   spike_ready,
   output logic                   clear,
   output logic                   busy,
   output logic                   overrun,
   output logic [7:0]             spike_count
);

   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [NUM_NEURONS-1:0] pending, pending_next;
   logic [NUM_NEURONS-1:0] lowest;
   logic [ADDR_W-1:0]      base_q, base_next;
   logic [IDX_W-1:0]       idx;
   logic                   accept;
   logic                   handshake;

   // Two's-complement trick isolates the lowest set bit of pending as a one-hot mask.
   assign lowest = pending & (~pending + NUM_NEURONS'(1));

   // Priority encode: scanning high-to-low leaves the lowest set index in idx.
   always_comb begin
      idx = '0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (pending[i]) idx = IDX_W'(i);
      end
   end

   assign accept    = (state == IDLE) && timestep_done;
   assign handshake = (state == SEND) && spike_ready;

   // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      base_next    = base_q;
      case (state)
         IDLE: begin
            if (timestep_done) begin
               pending_next = fire_vector;
               base_next    = base_address;
               state_next   = (|fire_vector) ? SEND : CLEAR;
            end
         end
         SEND: begin
            if (spike_ready) begin
               pending_next = pending & ~lowest;
               if (pending_next == '0) state_next = CLEAR;
            end
         end
         CLEAR:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         pending <= '0;
         base_q  <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         base_q  <= base_next;
         if (timestep_done && (state != IDLE)) overrun <= 1'b1;
      end
   end

   // Outputs depend only on registered state, never on spike_ready.
   assign spike_valid    = (state == SEND);
   assign clear          = (state == CLEAR);
   assign busy           = (state != IDLE);
   assign source_address = spike_valid ? (base_q + ADDR_W'(idx)) : '0;

`ifdef SPIKE_DISPATCH_COUNT_EN
   logic [7:0] count_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q <= '0;
      end else if (accept) begin
         count_q <= '0;
      end else if (handshake && (count_q != 8'hFF)) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign spike_count = count_q;
`else
   logic unused_count;
   assign unused_count = accept ^ handshake;
   assign spike_count  = '0;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// tb_spike_dispatcher: directed and randomized timesteps; a reference model lists the
// expected address stream per timestep and a negedge monitor checks it against the DUT.

module tb_spike_dispatcher;

   localparam int N  = 8;
   localparam int AW = 12;
`ifdef SPIKE_DISPATCH_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic          CLK           = 1'b0;
   logic          RESET         = 1'b1;
   logic [AW-1:0] base_address  = '0;
   logic [N-1:0]  fire_vector   = '0;
   logic          timestep_done = 1'b0;
   logic          spike_ready   = 1'b0;
   logic [AW-1:0] source_address;
   logic          spike_valid;
   logic          clear;
   logic          busy;
   logic          overrun;
   logic [7:0]    spike_count;

   spike_dispatcher #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .base_address  (base_address),
      .fire_vector   (fire_vector),
      .timestep_done (timestep_done),
      .source_address(source_address),
      .spike_valid   (spike_valid),
      .spike_ready   (spike_ready),
      .clear         (clear),
      .busy          (busy),
      .overrun       (overrun),
      .spike_count   (spike_count)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          is_clear;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t sb[$];

   // Expected stream: every fired neuron in ascending order, then one clear.
   function automatic void model_push(input logic [AW-1:0] base, input logic [N-1:0] fire);
      for (int i = 0; i < N; i++) begin
         if (fire[i]) sb.push_back('{is_clear: 1'b0, addr: base + AW'(i)});
      end
      sb.push_back('{is_clear: 1'b1, addr: '0});
   endfunction

   function automatic logic [7:0] count_model(input logic [N-1:0] fire);
      int c;
      c = $countones(fire);
      if (c > 255) c = 255;
      return COUNT_EN ? 8'(c) : 8'h00;
   endfunction

   // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
   bit            prev_stall = 1'b0;
   bit            clear_due  = 1'b0;
   logic [AW-1:0] prev_addr  = '0;
   exp_t          got;

   always @(negedge CLK) begin
      if (RESET) begin
         prev_stall = 1'b0;
         clear_due  = 1'b0;
      end else begin
         if (clear_due) check("clear_after_last_spike", clear, 1);
         clear_due = 1'b0;
         if (prev_stall) begin
            check("stall_valid_held", spike_valid, 1);
            check("stall_addr_stable", source_address, prev_addr);
         end
         if (clear || (spike_valid && spike_ready)) begin
            check("scoreboard_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               got = sb.pop_front();
               check("event_kind_is_clear", clear, got.is_clear);
               if (clear) check("valid_low_in_clear", spike_valid, 0);
               if (!got.is_clear) begin
                  check("spike_addr", source_address, got.addr);
                  if (sb.size() > 0 && sb[0].is_clear) clear_due = 1'b1;
               end
            end
         end
         prev_stall = spike_valid && !spike_ready;
         prev_addr  = source_address;
      end
   end

   int ready_mode = 0;

   always @(posedge CLK) begin
      #1;
      if (ready_mode == 1) spike_ready = ($urandom_range(0, 3) != 0);
   end

   // Called 1ns after a rising edge with the DUT idle; returns 1ns into the cycle after acceptance.
   task automatic pulse_ts(input logic [AW-1:0] base, input logic [N-1:0] fire);
      base_address  = base;
      fire_vector   = fire;
      timestep_done = 1'b1;
      model_push(base, fire);
      @(posedge CLK); #1;
      timestep_done = 1'b0;
      base_address  = AW'($urandom);
      fire_vector   = N'($urandom);
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("idle_within_budget", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0]  fire;
      logic [AW-1:0] base;

      // Reset values
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", spike_valid, 0);
      check("rst_clear", clear, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_addr", source_address, 0);
      check("rst_count", spike_count, 0);
      RESET = 1'b0;
      step();

      // Basic dispatch, ready held high
      spike_ready = 1'b1;
      pulse_ts(12'h100, 8'b0010_0101);
      check("basic_busy_t1", busy, 1);
      check("basic_valid_t1", spike_valid, 1);
      check("basic_addr0", source_address, 12'h100);
      step();
      check("basic_addr1", source_address, 12'h102);
      step();
      check("basic_addr2", source_address, 12'h105);
      step();
      check("basic_clear", clear, 1);
      check("basic_valid_in_clear", spike_valid, 0);
      step();
      check("basic_busy_drop", busy, 0);
      check("basic_clear_single", clear, 0);
      check("basic_count", spike_count, count_model(8'b0010_0101));

      // Empty vector
      pulse_ts(12'h200, 8'h00);
      check("empty_clear_t1", clear, 1);
      check("empty_valid_t1", spike_valid, 0);
      check("empty_busy_t1", busy, 1);
      step();
      check("empty_busy_drop", busy, 0);
      check("empty_clear_drop", clear, 0);
      check("empty_count", spike_count, 0);

      // Backpressure: ready low for 4 cycles, then high
      spike_ready = 1'b0;
      pulse_ts(12'h300, 8'h81);
      for (int i = 0; i < 4; i++) begin
         check("bp_valid_held", spike_valid, 1);
         check("bp_addr_held", source_address, 12'h300);
         step();
      end
      spike_ready = 1'b1;
      check("bp_valid_5th", spike_valid, 1);
      check("bp_addr_5th", source_address, 12'h300);
      step();
      check("bp_addr_second", source_address, 12'h307);
      step();
      check("bp_clear", clear, 1);
      wait_idle(10);
      check("bp_count", spike_count, count_model(8'h81));

      // Address wrap-around
      pulse_ts(12'hFFE, 8'h0C);
      check("wrap_addr0", source_address, 12'h000);
      step();
      check("wrap_addr1", source_address, 12'h001);
      wait_idle(10);
      check("overrun_clean_so_far", overrun, 0);

      // Overrun: second timestep_done while sending
      pulse_ts(12'h010, 8'hFF);
      step();
      base_address  = 12'h7FF;
      fire_vector   = 8'h0F;
      timestep_done = 1'b1;
      step();
      timestep_done = 1'b0;
      check("overrun_set", overrun, 1);
      wait_idle(20);
      check("overrun_sticky", overrun, 1);
      check("overrun_count", spike_count, count_model(8'hFF));
      pulse_ts(12'h020, 8'h03);
      wait_idle(10);
      check("overrun_still_set", overrun, 1);

      // Reset after the first of three handshakes
      pulse_ts(12'h400, 8'h07);
      step();
      RESET = 1'b1;
      sb.delete();
      step();
      check("mid_rst_valid", spike_valid, 0);
      check("mid_rst_clear", clear, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_addr", source_address, 0);
      check("mid_rst_count", spike_count, 0);
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_no_clear", clear, 0);
      end
      pulse_ts(12'h500, 8'h05);
      check("post_rst_addr0", source_address, 12'h500);
      wait_idle(10);
      check("post_rst_count", spike_count, count_model(8'h05));

      // Randomized timesteps with random backpressure
      ready_mode = 1;
      for (int t = 0; t < 40; t++) begin
         fire = N'($urandom);
         if ($urandom_range(0, 5) == 0) fire = '0;
         base = AW'($urandom);
         if ($urandom_range(0, 4) == 0) base = AW'(12'hFF8 + $urandom_range(0, 7));
         pulse_ts(base, fire);
         wait_idle(300);
         check("rand_count", spike_count, count_model(fire));
         repeat ($urandom_range(0, 2)) step();
      end
      ready_mode = 0;
      step();
      check("final_overrun_clear", overrun, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spike_dispatcher.md
# spike_dispatcher

Transmit-side end of the spike interface: it takes the fire vector produced by a tile's neuron potential units at the end of a timestep and serializes each fired neuron into a 12-bit source address on a valid/ready stream toward the NoC/MAC receivers. After the last address of the timestep has been accepted, it issues a single-cycle `clear` pulse. That pulse marks the timestep boundary and causes receiving MACs to accumulate their recorded spikes.

## Interface
- `NUM_NEURONS`, default 8: neurons served by this dispatcher (1..64).
- `ADDR_W`, default 12: source address width.
- `CLK`, input, 1: the single clock; all state changes on its rising edge.
- `RESET`, input, 1: reset is synchronous and active-high.
- `base_address`, input, ADDR_W: address of neuron 0; sampled at latch time.
- `fire_vector`, input, NUM_NEURONS: bit i = neuron i fired this timestep.
- `timestep_done`, input, 1: single-cycle pulse; latch `fire_vector` and start dispatch.
- `source_address`, output, ADDR_W: address of the spike currently offered.
- `spike_valid`, output, 1: `source_address` is valid.
- `spike_ready`, input, 1: downstream accepts; transfer occurs when valid and ready are both high at a rising edge.
- `clear`, output, 1: one-cycle timestep-end pulse to the receivers.
- `busy`, output, 1: high while the FSM is not IDLE.
- `overrun`, output, 1: sticky; `timestep_done` arrived while busy.
- `spike_count`, output, 8: spikes sent in the current or last timestep (see Configuration).

## Operation
- The FSM has three states: IDLE, SEND and CLEAR.
- IDLE:
  - When `timestep_done` is high, latch `fire_vector` into `pending` and `base_address` into `base_q`.
  - If the latched vector is nonzero, go to SEND; otherwise go to CLEAR.
- SEND:
  - `idx` is the lowest set bit of `pending`, found by combinational priority encode.
  - `source_address` = `base_q` + `idx`, taken mod 2^ADDR_W, so it wraps at 0xFFF.
  - `spike_valid` is high in every SEND cycle.
  - On a handshake, clear `pending[idx]`. If `pending` becomes zero, go to CLEAR; otherwise stay in SEND with the next lowest index.
- CLEAR:
  - `clear` is high for exactly one cycle and `spike_valid` is low.
  - Then go to IDLE.
- `timestep_done` is ignored in SEND and CLEAR, and sets `overrun`. Only `RESET` clears `overrun`.
- Changes to `fire_vector` or `base_address` after latch have no effect on the timestep in progress.
- While `spike_valid` is high and `spike_ready` is low, `source_address` must stay stable.
- Spikes are dispatched in strictly ascending neuron index; there are no duplicates and none are dropped.
- `RESET` during any state:
  - Return to IDLE next edge and zero `pending`.
  - The aborted timestep produces no `clear` pulse.

## Timing
- Reset values: `spike_valid`=0, `clear`=0, `busy`=0, `overrun`=0, `source_address`=0, `spike_count`=0.
- If `timestep_done` is sampled at edge t:
  - `busy` and the first `spike_valid` are high in cycle t+1.
  - For an empty vector, `clear` is high in cycle t+1 instead.
- Throughput is 1 spike/cycle while `spike_ready` is held high. With k set bits and ready held high, the final handshake is at edge t+k.
- After the final handshake at edge e:
  - `clear` is high in cycle e+1.
  - `busy` drops in cycle e+2.
  - A new `timestep_done` is accepted from cycle e+2.
- `source_address` is registered-state driven (`pending`, `base_q`). It has no combinational path from `spike_ready`.

## Configuration
- `SPIKE_DISPATCH_COUNT_EN` defined:
  - `spike_count` resets to 0 on each accepted `timestep_done`.
  - It increments on each handshake and saturates at 255.
  - It holds its value through IDLE until the next timestep.
- `SPIKE_DISPATCH_COUNT_EN` not defined: `spike_count` is tied to 0 and no counter logic is built.

## Test plan
- `base_address`=0x100, `fire_vector`=0b0010_0101, ready held high:
  - Addresses 0x100, 0x102, 0x105 on three consecutive cycles.
  - `clear` pulses once, the cycle after 0x105.
  - `spike_count`=3 when the macro is enabled.
- `fire_vector`=0, `timestep_done` pulse: no `spike_valid`, `clear` high in the next cycle, `busy` high for one cycle.
- Backpressure, with `fire_vector`=0x81 and ready low for 4 cycles then high:
  - 0x000+base is held stable with valid high for 5 cycles, then 7+base is sent.
  - No spike is lost.
- Wrap-around: `base_address`=0xFFE, `fire_vector`=0x0C → addresses 0x000, then 0x001.
- Second `timestep_done` during SEND → `overrun`=1 and stays 1; the current dispatch completes unchanged.
- `RESET` asserted after the first of three handshakes:
  - All outputs return to reset values next cycle with no `clear` pulse.
  - A new timestep afterward dispatches normally.
